// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle stalling data memory (IDLE -> BUSY x LATENCY -> DONE).
// Define DATA_MEM_ALIGN_CHK_EN to flag odd byte addresses as error transactions.
module data_mem_ctrl #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [15:0] wdata_q, wdata_d, data_out_q, data_out_d;
  logic [15:0] mem [2**DEPTH_LOG2];
  logic req, bad, finish, unused;
  assign req = rd | wr;
`ifdef DATA_MEM_ALIGN_CHK_EN
  assign bad = (rd & wr) | addr[0];
`else
  assign bad = rd & wr;
`endif
  assign unused = ^{addr[15:DEPTH_LOG2+1], addr[0]};
  assign finish = state_q == BUSY && cnt_q == 4'd0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    err_d = err_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    data_out_d = data_out_q;
    unique case (state_q)
      IDLE: if (req) begin
        state_d = BUSY;
        cnt_d = 4'(LATENCY - 1);
        wr_d = wr;
        err_d = bad;
        idx_d = addr[DEPTH_LOG2:1];
        wdata_d = data_in;
      end
      BUSY: if (cnt_q == 4'd0) begin
        state_d = DONE;
        data_out_d = err_q ? 16'h0 : (wr_q ? data_out_q : mem[idx_q]);
      end else cnt_d = cnt_q - 4'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= 16'h0;
      data_out_q <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      err_q <= err_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      data_out_q <= data_out_d;
    end
  end
  // Array has no reset; an abandoned write never reaches here because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (finish && wr_q && !err_q) mem[idx_q] <= wdata_q;
  end
  assign stall = (state_q == IDLE && req) || state_q == BUSY;
  assign done = state_q == DONE;
  assign err = done & err_q;
  assign data_out = data_out_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed scoreboard bench; u0 uses LATENCY=4, u1 uses LATENCY=1.
module tb_data_mem_ctrl;
`ifdef DATA_MEM_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  typedef struct {logic [15:0] d; logic e;} exp_t;
  logic clk = 1'b0, rst = 1'b0;
  logic rd_v [2], wr_v [2], stall_v [2], done_v [2], err_v [2];
  logic [15:0] addr_v [2], din_v [2], dout_v [2];
  logic [15:0] mdl [2][1024];
  logic [15:0] last [2];
  exp_t sbq [$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_LOG2(10), .LATENCY(4)) u0 (
    .clk(clk), .rst(rst), .rd(rd_v[0]), .wr(wr_v[0]), .addr(addr_v[0]), .data_in(din_v[0]),
    .data_out(dout_v[0]), .stall(stall_v[0]), .done(done_v[0]), .err(err_v[0]));
  data_mem_ctrl #(.DEPTH_LOG2(10), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .rd(rd_v[1]), .wr(wr_v[1]), .addr(addr_v[1]), .data_in(din_v[1]),
    .data_out(dout_v[1]), .stall(stall_v[1]), .done(done_v[1]), .err(err_v[1]));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // One transaction on DUT sel, starting in an IDLE cycle; checks every cycle to DONE.
  task automatic txn(input int sel, input logic r, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input bit toggle);
    int lat;
    exp_t x, y;
    logic [9:0] idx;
    lat = sel ? 1 : 4;
    idx = a[10:1];
    x.e = (r & w) | (ALIGN & a[0]);
    if (x.e) x.d = 16'h0;
    else if (w) begin
      mdl[sel][idx] = d;
      x.d = last[sel];
    end else x.d = mdl[sel][idx];
    last[sel] = x.d;
    sbq.push_back(x);
    @(negedge clk);
    rd_v[sel] = r; wr_v[sel] = w; addr_v[sel] = a; din_v[sel] = d;
    #1 chk("stall_c0", 16'(stall_v[sel]), 16'h1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      #1 chk("stall_busy", 16'(stall_v[sel]), 16'h1);
      chk("done_busy", 16'(done_v[sel]), 16'h0);
      if (toggle) begin
        rd_v[sel] = ~rd_v[sel];
        addr_v[sel] = 16'($urandom);
        din_v[sel] = 16'($urandom);
      end
    end
    @(negedge clk);
    #1 y = sbq.pop_front();
    chk("done", 16'(done_v[sel]), 16'h1);
    chk("stall_done", 16'(stall_v[sel]), 16'h0);
    chk("err", 16'(err_v[sel]), 16'(y.e));
    chk("data_out", dout_v[sel], y.d);
    rd_v[sel] = 1'b0; wr_v[sel] = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rd_v[s] = 0; wr_v[s] = 0; addr_v[s] = 0; din_v[s] = 0; last[s] = 0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_dout", dout_v[s], 16'h0);
      chk("rst_done", 16'(done_v[s]), 16'h0);
      chk("rst_err", 16'(err_v[s]), 16'h0);
      chk("rst_stall", 16'(stall_v[s]), 16'h0);
    end
    rst = 1'b1;
    txn(0, 0, 1, 16'h0010, 16'h1111, 0);
    txn(0, 1, 0, 16'h0010, 16'h0, 0);
    // Abandon a write of 0xBEEF mid-BUSY with an asynchronous reset.
    @(negedge clk);
    wr_v[0] = 1; addr_v[0] = 16'h0010; din_v[0] = 16'hBEEF;
    @(negedge clk);
    wr_v[0] = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("arst_dout", dout_v[0], 16'h0);
    chk("arst_stall", 16'(stall_v[0]), 16'h0);
    chk("arst_done", 16'(done_v[0]), 16'h0);
    @(negedge clk);
    rst = 1'b1; last[0] = 0; last[1] = 0;
    txn(0, 1, 0, 16'h0010, 16'h0, 0);
    txn(0, 0, 1, 16'h0020, 16'h1234, 0);
    txn(0, 1, 0, 16'h0020, 16'h0, 0);
    txn(0, 0, 1, 16'h0000, 16'hAAAA, 0);
    txn(0, 0, 1, 16'h0800, 16'h5555, 0);
    txn(0, 1, 0, 16'h0000, 16'h0, 0);
    txn(0, 0, 1, 16'h0004, 16'h4444, 0);
    txn(0, 1, 1, 16'h0004, 16'hFFFF, 0);
    txn(0, 1, 0, 16'h0004, 16'h0, 0);
    txn(0, 0, 1, 16'h0002, 16'h1010, 0);
    txn(0, 0, 1, 16'h0003, 16'h7777, 0);
    txn(0, 1, 0, 16'h0002, 16'h0, 0);
    txn(0, 1, 0, 16'h0020, 16'h0, 1);
    txn(1, 0, 1, 16'h0006, 16'h9999, 0);
    txn(1, 1, 0, 16'h0006, 16'h0, 1);
    txn(1, 0, 1, 16'h0008, 16'h3C3C, 0);
    txn(1, 1, 1, 16'h0008, 16'h0F0F, 0);
    txn(1, 1, 0, 16'h0008, 16'h0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Multi-cycle data-memory responder serving the load/store requests issued by the processor's memory stage. It accepts one read or write per transaction, holds the requester with `stall` for a fixed, parameterised latency, and completes with a one-cycle `done` pulse carrying read data or write acknowledgement. It sits between the memory stage and the data storage array, and replaces the single-cycle data memory when the stalling-memory configuration is built.

## Interface
Parameters:
- `DEPTH_LOG2`, 10, log2 of the number of 16-bit words in the internal array (1024 words).
- `LATENCY`, 4, number of BUSY cycles per transaction; legal range 1 to 15.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous and active-low (asserted when 0).
- `rd`  input  1  read request, sampled only in IDLE.
- `wr`  input  1  write request, sampled only in IDLE.
- `addr`  input  16  byte address; word index is `addr[DEPTH_LOG2:1]`; higher bits are ignored and alias.
- `data_in`  input  16  write data, captured on the accept edge.
- `data_out`  output  16  registered read data; updated only on entry to DONE.
- `stall`  output  1  requester must hold its request and freeze.
- `done`  output  1  one-cycle completion pulse.
- `err`  output  1  completion with error; valid only while `done` is high, 0 otherwise.

## Operation
- States: IDLE, BUSY, DONE. The 4-bit down-counter `cnt` runs only in BUSY.
- IDLE: if `rd | wr`, capture the op, `addr` and `data_in`, load `cnt = LATENCY-1`, and go to BUSY. Otherwise stay in IDLE.
- BUSY: `rd`, `wr`, `addr` and `data_in` are ignored. If `cnt == 0`, go to DONE; otherwise decrement `cnt`.
- Actions on the BUSY→DONE edge:
  - Write: commit `data_in` to the array.
  - Read: load `data_out` from the array.
  - Error transaction: no write is committed and `data_out` is loaded with 0.
- DONE: lasts one cycle, then returns to IDLE unconditionally. Request inputs are ignored in DONE.
- Error conditions:
  - `rd & wr` asserted together at accept is always an error.
  - An unaligned address is an error only when alignment checking is compiled in (see Configuration).
- `stall` is combinational: high when (IDLE and `rd | wr`) or BUSY; low in DONE and in idle-without-request.
- `done` is high exactly in DONE. `err` equals `done` ANDed with the captured error flag.
- `data_out` holds its last value outside DONE-entry edges.
- Reset:
  - Forces IDLE, `cnt = 0`, `data_out = 0`, `done = 0`, `err = 0`; `stall` = 0 until a request is seen.
  - Array contents are not reset.
  - Reset during BUSY abandons the transaction; a pending write is never committed.
- Back-to-back transactions: the requester advances on the DONE cycle. A request presented in the following IDLE cycle is accepted, giving one transaction per LATENCY+2 cycles.

## Timing
- Request presented in cycle 0 (IDLE): `stall` is high in cycle 0, BUSY occupies cycles 1..LATENCY, and DONE is cycle LATENCY+1.
- `stall` is high in cycles 0..LATENCY and low in cycle LATENCY+1.
- The write is visible to a read accepted in cycle LATENCY+2 or later.
- `data_out` is valid from cycle LATENCY+1 until the next DONE entry.
- With the default LATENCY=4, `done` is high in cycle 5.

## Configuration
- Macro: `DATA_MEM_ALIGN_CHK_EN`.
- Defined: `addr[0] == 1` at accept marks the transaction as an error. It still takes full latency, writes nothing, returns `data_out = 0`, and raises `err` with `done`.
- Undefined: `addr[0]` is ignored and unaligned accesses act on word `addr[DEPTH_LOG2:1]`. `err` is raised only for `rd & wr`.

## Test plan
- Reset with `rst=0` mid-BUSY, after a write to 0x0010 of 0xBEEF is accepted -> outputs go to 0 immediately. A later read of 0x0010 does not return 0xBEEF.
- Write 0x1234 to 0x0020, then read 0x0020 in the first IDLE after DONE -> read `done` in cycle 5 of that transaction, `data_out = 0x1234`, `err = 0`, `stall` high in cycles 0..4.
- Write 0xAAAA to 0x0000 and 0x5555 to 0x0800 (alias with DEPTH_LOG2=10) -> a read of 0x0000 returns 0x5555.
- `rd=1`, `wr=1` at addr 0x0004 with `data_in=0xFFFF` -> `done` and `err` high in cycle 5, `data_out = 0`. A read of 0x0004 is unchanged from its prior value.
- With `DATA_MEM_ALIGN_CHK_EN`, write 0x7777 to 0x0003 -> `err = 1` at `done` and word 1 is unchanged. Without the macro, the same write sets word 1 to 0x7777 with `err = 0`.
- `LATENCY=1` build, read request -> `stall` high in cycles 0..1 and `done` in cycle 2. Toggling `rd` and `addr` during BUSY has no effect on `data_out`.
